sweep_sequencer: RTL and testbench
==================================

Name: sweep_sequencer

Overview:
- Programmable scheduler that feeds the frequency sweeper's 88-bit instruction FIFO.
- Holds a small table of instruction segments: sweep, PLL lock or dissipation measurement.
- Issues the segments in order, one FIFO write per segment, and waits for each to finish before issuing the next.
- Repeats the whole table a configured number of times. Sits between the host configuration registers and the sweeper's FIFO write port.

Parameters:
- SEG_DEPTH, 8: number of segment table entries (power of two).
- SEG_AW, 3: table address width, log2(SEG_DEPTH).
- TIMEOUT_CYCLES, 32'd2000000: maximum wait for sweep_done on an opcode-0 segment.
- HOLD_CYCLES, 32'd70000: fixed dwell for non-sweep opcodes (1 = dissipation, 255 = PLL lock).

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  segment table write strobe.
- cfg_addr  in  SEG_AW  table write address.
- cfg_wdata  in  88  instruction word: [87:80] opcode, [79:48] init_freq, [47:32] cycles_per_step, [31:0] freq_step.
- cfg_num_segs  in  SEG_AW+1  segments per pass, 0..SEG_DEPTH.
- cfg_repeat  in  8  number of passes; 0 = run until abort.
- start  in  1  begin a run (level sampled).
- abort  in  1  stop a run.
- fifo_full  in  1  instruction FIFO full.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  88  instruction being written.
- sweep_done  in  1  completion pulse from the sweeper.
- busy  out  1  run in progress.
- seg_index  out  SEG_AW  segment currently active.
- pass_count  out  8  passes completed in this run.
- done  out  1  one-cycle pulse at end of run.
- timeout_err  out  1  sticky error flag, cleared by an accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; table contents undefined (not reset).
- Table writes:
  - cfg_we is honoured only while busy = 0; writes while busy are dropped.
  - cfg_num_segs and cfg_repeat are latched when start is accepted; later changes do not affect the run.
- State machine: IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE:
  - start = 1 with cfg_num_segs != 0: go to ISSUE, set busy = 1, clear seg_index, pass_count and timeout_err.
  - start = 1 with cfg_num_segs = 0: go straight to FINISH with no FIFO write.
- ISSUE:
  - fifo_wr_data = table[seg_index] (registered).
  - If fifo_full = 0: fifo_wr_en = 1 for exactly one cycle, then go to WAIT and clear the wait counter.
  - If fifo_full = 1: stay in ISSUE, fifo_wr_en = 0.
  - Latency: fifo_wr_en is high in the 2nd cycle after start is sampled, given fifo_full = 0.
- WAIT, opcode 0:
  - Advance to NEXT on sweep_done = 1.
  - If the counter reaches TIMEOUT_CYCLES-1 without sweep_done: set timeout_err, go to FINISH.
  - sweep_done in the same cycle as the timeout: done path wins, no error.
- WAIT, any other opcode: ignore sweep_done; advance to NEXT after HOLD_CYCLES cycles.
- NEXT:
  - If seg_index = num_segs-1: clear seg_index, increment pass_count (8-bit wrap).
    - If repeat != 0 and the new pass_count = repeat: go to FINISH.
    - Otherwise go to ISSUE.
  - Otherwise: increment seg_index, go to ISSUE.
- FINISH: done = 1 for one cycle, busy = 0, go to IDLE.
- Abort:
  - abort = 1 in any non-IDLE state: next state IDLE, busy = 0, fifo_wr_en = 0, no done pulse.
  - abort beats a simultaneous sweep_done or FIFO write. If abort and the ISSUE write coincide, the write is suppressed.
  - abort in IDLE has no effect.
- Start while busy is ignored.
- Reset mid-run: immediate return to reset values at the next edge; no done pulse.
- Wait counter: 32-bit, saturating, cleared on entry to WAIT.

Decomposition:
- Shared package sweep_pkg holds:
  - opcode constants OP_SWEEP = 8'd0, OP_DISSIPATION = 8'd1, OP_PLL = 8'd255;
  - instruction field bit positions (the [87:80], [79:48], [47:32], [31:0] slices);
  - the 88-bit instruction width.
- One natural sub-module: sweep_seg_table, a SEG_DEPTH x 88 register file with synchronous write and registered read. The FSM is the top-level module.

Test Plan:
- 2 sweep segments (init_freq 0x1000/step 0x10 and 0x2000/step 0x20), repeat = 1: start; reply to each write with sweep_done after 100 cycles.
  - Expect exactly 2 fifo_wr_en pulses with matching fifo_wr_data, in order.
  - Expect pass_count = 1 and one done pulse.
- fifo_full held high 50 cycles after start → fifo_wr_en stays 0; exactly one write in the cycle after fifo_full drops.
- 1 opcode-255 segment, HOLD_CYCLES = 200, sweep_done pulsed mid-hold → sweep_done ignored; done exactly 200 cycles after the write, plus FSM overhead.
- Opcode-0 segment, TIMEOUT_CYCLES = 500, no sweep_done → timeout_err = 1 and a done pulse about 500 cycles after the write; timeout_err cleared by the next start.
- cfg_repeat = 0, 1 segment, sweep_done each time; abort after the 3rd write.
  - busy falls the next cycle; no 4th write; no done pulse.
  - cfg_we while busy leaves table contents unchanged.
- cfg_num_segs = 0, start → done pulse 2 cycles later, no fifo_wr_en; synchronous reset asserted mid-WAIT clears busy/seg_index at the next edge.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep sequencer: instruction layout, opcodes, FSM states.
package sweep_pkg;

    // 88-bit sweeper instruction word
    localparam int unsigned INSTR_W = 88;

    // Instruction field bit positions
    localparam int unsigned OP_HI   = 87;
    localparam int unsigned OP_LO   = 80;
    localparam int unsigned FREQ_HI = 79;
    localparam int unsigned FREQ_LO = 48;
    localparam int unsigned CPS_HI  = 47;
    localparam int unsigned CPS_LO  = 32;
    localparam int unsigned STEP_HI = 31;
    localparam int unsigned STEP_LO = 0;

    // Segment opcodes
    localparam logic [7:0] OP_SWEEP       = 8'd0;
    localparam logic [7:0] OP_DISSIPATION = 8'd1;
    localparam logic [7:0] OP_PLL         = 8'd255;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    // Field view of an instruction word
    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] init_freq;
        logic [15:0] cycles_per_step;
        logic [31:0] freq_step;
    } instr_t;

    // Extract the opcode of an instruction word
    function automatic logic [7:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

    // Assemble an instruction word from its fields
    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [7:0]  opcode,
        input logic [31:0] init_freq,
        input logic [15:0] cycles_per_step,
        input logic [31:0] freq_step
    );
        logic [INSTR_W-1:0] w;
        w                  = '0;
        w[OP_HI:OP_LO]     = opcode;
        w[FREQ_HI:FREQ_LO] = init_freq;
        w[CPS_HI:CPS_LO]   = cycles_per_step;
        w[STEP_HI:STEP_LO] = freq_step;
        return w;
    endfunction

endpackage

// File: rtl/sweep_seg_table.sv
// Segment table: SEG_DEPTH x 88-bit register file, synchronous write, registered read.
// Ports:
//   clk    - system clock
//   we     - write strobe
//   waddr  - write address
//   wdata  - write data (instruction word)
//   raddr  - read address, sampled every clock
//   rdata  - registered read data (entry at raddr from the previous cycle)
module sweep_seg_table
    import sweep_pkg::*;
#(
    parameter int unsigned SEG_DEPTH = 8,
    parameter int unsigned SEG_AW    = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [SEG_AW-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [SEG_AW-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [SEG_DEPTH];

    // Storage is intentionally not reset; contents are undefined until written
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Sweep sequencer: issues a table of instruction segments to the sweeper FIFO,
// one write per segment, waiting for each segment to complete, repeating the
// table a configured number of passes.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cfg_we/addr/wdata   - segment table write port (honoured only when not busy)
//   cfg_num_segs        - segments per pass (0..SEG_DEPTH), latched at start
//   cfg_repeat          - passes per run, 0 = until abort, latched at start
//   start, abort        - run control
//   fifo_full           - sweeper FIFO backpressure
//   fifo_wr_en/data     - sweeper FIFO write port
//   sweep_done          - sweeper completion pulse
//   busy, seg_index     - run status
//   pass_count          - passes completed in this run
//   done                - one-cycle end-of-run pulse
//   timeout_err         - sticky sweep timeout flag, cleared by an accepted start
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int unsigned SEG_DEPTH      = 8,
    parameter int unsigned SEG_AW         = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
    parameter logic [31:0] HOLD_CYCLES    = 32'd70000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [SEG_AW-1:0]  cfg_addr,
    input  logic [INSTR_W-1:0] cfg_wdata,
    input  logic [SEG_AW:0]    cfg_num_segs,
    input  logic [7:0]         cfg_repeat,
    input  logic               start,
    input  logic               abort,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [INSTR_W-1:0] fifo_wr_data,
    input  logic               sweep_done,
    output logic               busy,
    output logic [SEG_AW-1:0]  seg_index,
    output logic [7:0]         pass_count,
    output logic               done,
    output logic               timeout_err
);

    localparam int unsigned CNT_W = SEG_AW + 1;

    seq_state_t         state;
    logic [CNT_W-1:0]   num_segs;
    logic [7:0]         run_repeat;
    logic [31:0]        wait_cnt;
    logic [7:0]         cur_op;
    logic [INSTR_W-1:0] rd_data;
    logic [SEG_AW-1:0]  rd_addr_c;
    logic               last_seg_c;
    logic [7:0]         pass_inc_c;

    assign last_seg_c = ({1'b0, seg_index} == (num_segs - CNT_W'(1)));
    assign pass_inc_c = pass_count + 8'd1;

    // Read address looks ahead to the segment index the FSM is about to use,
    // so the registered read data is already valid in the first ISSUE cycle.
    always_comb begin
        rd_addr_c = seg_index;
        if (state == ST_IDLE) begin
            rd_addr_c = '0;
        end else if (state == ST_NEXT) begin
            rd_addr_c = last_seg_c ? '0 : (seg_index + SEG_AW'(1));
        end
    end

    sweep_seg_table #(
        .SEG_DEPTH (SEG_DEPTH),
        .SEG_AW    (SEG_AW)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we && !busy),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr_c),
        .rdata (rd_data)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            seg_index    <= '0;
            pass_count   <= 8'd0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            num_segs     <= '0;
            run_repeat   <= 8'd0;
            wait_cnt     <= 32'd0;
            cur_op       <= 8'd0;
        end else begin
            fifo_wr_en <= 1'b0;
            done       <= 1'b0;

            // Abort outranks every other event outside IDLE
            if ((state != ST_IDLE) && abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            num_segs    <= cfg_num_segs;
                            run_repeat  <= cfg_repeat;
                            seg_index   <= '0;
                            pass_count  <= 8'd0;
                            timeout_err <= 1'b0;
                            if (cfg_num_segs != '0) begin
                                busy  <= 1'b1;
                                state <= ST_ISSUE;
                            end else begin
                                state <= ST_FINISH;
                            end
                        end
                    end

                    ST_ISSUE: begin
                        if (!fifo_full) begin
                            fifo_wr_en   <= 1'b1;
                            fifo_wr_data <= rd_data;
                            cur_op       <= instr_opcode(rd_data);
                            wait_cnt     <= 32'd0;
                            state        <= ST_WAIT;
                        end
                    end

                    ST_WAIT: begin
                        if (cur_op == OP_SWEEP) begin
                            // Completion wins over a coincident timeout
                            if (sweep_done) begin
                                state <= ST_NEXT;
                            end else if (wait_cnt == (TIMEOUT_CYCLES - 32'd1)) begin
                                timeout_err <= 1'b1;
                                busy        <= 1'b0;
                                state       <= ST_FINISH;
                            end
                        end else if (wait_cnt == (HOLD_CYCLES - 32'd1)) begin
                            state <= ST_NEXT;
                        end
                        if (wait_cnt != 32'hFFFF_FFFF) begin
                            wait_cnt <= wait_cnt + 32'd1;
                        end
                    end

                    ST_NEXT: begin
                        if (last_seg_c) begin
                            seg_index  <= '0;
                            pass_count <= pass_inc_c;
                            if ((run_repeat != 8'd0) && (pass_inc_c == run_repeat)) begin
                                state <= ST_FINISH;
                            end else begin
                                state <= ST_ISSUE;
                            end
                        end else begin
                            seg_index <= seg_index + SEG_AW'(1);
                            state     <= ST_ISSUE;
                        end
                    end

                    ST_FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard testbench for sweep_sequencer.
module tb_sweep_sequencer;

    localparam int unsigned TB_TIMEOUT = 500;
    localparam int unsigned TB_HOLD    = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [87:0] cfg_wdata;
    logic [3:0]  cfg_num_segs;
    logic [7:0]  cfg_repeat;
    logic        start;
    logic        abort;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [87:0] fifo_wr_data;
    logic        sweep_done = 1'b0;
    logic        busy;
    logic [2:0]  seg_index;
    logic [7:0]  pass_count;
    logic        done;
    logic        timeout_err;

    sweep_sequencer #(
        .SEG_DEPTH      (8),
        .SEG_AW         (3),
        .TIMEOUT_CYCLES (32'(TB_TIMEOUT)),
        .HOLD_CYCLES    (32'(TB_HOLD))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_num_segs (cfg_num_segs),
        .cfg_repeat   (cfg_repeat),
        .start        (start),
        .abort        (abort),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .sweep_done   (sweep_done),
        .busy         (busy),
        .seg_index    (seg_index),
        .pass_count   (pass_count),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       chk_pc;
        logic [7:0] pc;
        logic       err;
    } done_exp_t;

    logic [87:0] exp_wr[$];
    done_exp_t   exp_done[$];
    logic [87:0] model_tab [8];

    int vectors = 0;
    int errors  = 0;

    int wr_cnt = 0;
    int done_cnt = 0;
    int first_wr_cyc = -1;
    int done_cyc = -1;
    int t_start = 0;

    // FIFO backpressure: forced level or random
    logic fifo_force = 1'b0;
    logic fifo_rand = 1'b0;
    logic fifo_rnd_bit = 1'b0;
    assign fifo_full = fifo_rand ? fifo_rnd_bit : fifo_force;
    always @(negedge clk) fifo_rnd_bit <= ($urandom_range(0, 3) == 0);

    // Sweeper responder: pulse sweep_done a programmed delay after each write (0 = never)
    int resp_delay = 0;
    int resp_plan[$];
    int pend = 0;
    always @(negedge clk) begin
        sweep_done = 1'b0;
        if (reset) begin
            pend = 0;
        end else if (fifo_wr_en) begin
            if (resp_plan.size() > 0) pend = resp_plan.pop_front();
            else pend = resp_delay;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) sweep_done = 1'b1;
        end
    end

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop expectations whenever the DUT presents a write or a done pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_wr_en) begin
                wr_cnt++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (exp_wr.size() == 0) check("unexpected_write", 88'd1, 88'd0);
                else check("wr_data", fifo_wr_data, exp_wr.pop_front());
            end
            if (done) begin
                done_exp_t d;
                done_cnt++;
                done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 88'd1, 88'd0);
                end else begin
                    d = exp_done.pop_front();
                    check("done_timeout_err", 88'(timeout_err), 88'(d.err));
                    if (d.chk_pc) check("done_pass_count", 88'(pass_count), 88'(d.pc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tab(input int addr, input logic [87:0] data, input bit idle);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(addr);
        cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idle) model_tab[addr] = data;
    endtask

    function automatic logic [87:0] instr(input logic [7:0] op, input logic [31:0] f,
                                          input logic [15:0] c, input logic [31:0] s);
        return {op, f, c, s};
    endfunction

    // Reference: a completed run writes the first n entries, r times over, then one done
    task automatic predict_run(input int n, input int r);
        done_exp_t d;
        for (int p = 0; p < r; p++)
            for (int s = 0; s < n; s++)
                exp_wr.push_back(model_tab[s]);
        d.chk_pc = 1'b1;
        d.pc     = 8'(r);
        d.err    = 1'b0;
        exp_done.push_back(d);
    endtask

    task automatic reset_run();
        wr_cnt = 0;
        done_cnt = 0;
        first_wr_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic do_start(input int n, input int r);
        cfg_num_segs = 4'(n);
        cfg_repeat   = 8'(r);
        start        = 1'b1;
        @(posedge clk);
        #1 t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        cfg_num_segs = 4'($urandom_range(0, 8));
        cfg_repeat   = 8'($urandom);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int b = budget;
        while (wr_cnt < target && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("wait_write_bound", 88'(wr_cnt >= target), 88'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int b = budget;
        while (done_cnt < target && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("wait_done_bound", 88'(done_cnt >= target), 88'd1);
    endtask

    initial begin
        done_exp_t d;
        logic [87:0] junk;
        int gap;

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_num_segs = '0; cfg_repeat = '0; start = 1'b0; abort = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_busy", 88'(busy), 88'd0);
        check("reset_wr_en", 88'(fifo_wr_en), 88'd0);
        check("reset_wr_data", fifo_wr_data, 88'd0);
        check("reset_seg_index", 88'(seg_index), 88'd0);
        check("reset_pass_count", 88'(pass_count), 88'd0);
        check("reset_done", 88'(done), 88'd0);
        check("reset_timeout_err", 88'(timeout_err), 88'd0);

        // Two sweep segments, one pass
        write_tab(0, instr(8'd0, 32'h1000, 16'h0040, 32'h10), 1'b1);
        write_tab(1, instr(8'd0, 32'h2000, 16'h0080, 32'h20), 1'b1);
        resp_delay = 100;
        reset_run();
        predict_run(2, 1);
        do_start(2, 1);
        check("busy_after_start", 88'(busy), 88'd1);
        wait_done(1, 1000);
        check("first_write_latency", 88'(first_wr_cyc - t_start), 88'd1);
        check("two_seg_writes", 88'(wr_cnt), 88'd2);
        check("two_seg_pass_count", 88'(pass_count), 88'd1);
        check("two_seg_busy_end", 88'(busy), 88'd0);

        // FIFO full for 50 cycles after start
        write_tab(0, instr(8'd0, $urandom, 16'($urandom), $urandom), 1'b1);
        resp_delay = 10;
        fifo_force = 1'b1;
        reset_run();
        predict_run(1, 1);
        do_start(1, 1);
        tick(50);
        check("no_write_while_full", 88'(wr_cnt), 88'd0);
        fifo_force = 1'b0;
        gap = cyc;
        wait_done(1, 500);
        check("write_after_full_drop", 88'(first_wr_cyc - gap), 88'd1);
        check("full_single_write", 88'(wr_cnt), 88'd1);

        // PLL-lock hold; sweep_done mid-hold must be ignored
        write_tab(0, instr(8'd255, $urandom, 16'($urandom), $urandom), 1'b1);
        resp_delay = 50;
        reset_run();
        predict_run(1, 1);
        do_start(1, 1);
        wait_done(1, 1000);
        gap = done_cyc - first_wr_cyc;
        check("hold_gap_window", 88'(gap >= int'(TB_HOLD) && gap <= int'(TB_HOLD) + 4), 88'd1);

        // Sweep timeout with no sweep_done
        write_tab(0, instr(8'd0, $urandom, 16'($urandom), $urandom), 1'b1);
        resp_delay = 0;
        reset_run();
        exp_wr.push_back(model_tab[0]);
        d.chk_pc = 1'b1; d.pc = 8'd0; d.err = 1'b1;
        exp_done.push_back(d);
        do_start(1, 1);
        wait_done(1, 2000);
        gap = done_cyc - first_wr_cyc;
        check("timeout_gap_window", 88'(gap >= int'(TB_TIMEOUT) && gap <= int'(TB_TIMEOUT) + 4), 88'd1);
        check("timeout_err_set", 88'(timeout_err), 88'd1);

        // Endless repeat, aborted after the third write; busy table write dropped
        resp_delay = 20;
        reset_run();
        for (int i = 0; i < 3; i++) exp_wr.push_back(model_tab[0]);
        do_start(1, 0);
        check("timeout_err_cleared", 88'(timeout_err), 88'd0);
        wait_wr(2, 200);
        junk = instr(8'd1, $urandom, 16'($urandom), $urandom);
        write_tab(0, junk, 1'b0);
        wait_wr(3, 200);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_low", 88'(busy), 88'd0);
        check("abort_pass_count", 88'(pass_count), 88'd2);
        tick(100);
        check("abort_no_4th_write", 88'(wr_cnt), 88'd3);
        check("abort_no_done", 88'(done_cnt), 88'd0);

        // Table entry untouched by the busy write
        resp_delay = 15;
        reset_run();
        predict_run(1, 1);
        do_start(1, 1);
        wait_done(1, 500);

        // Zero segments: done only
        reset_run();
        d.chk_pc = 1'b0; d.pc = 8'd0; d.err = 1'b0;
        exp_done.push_back(d);
        do_start(0, 1);
        wait_done(1, 20);
        check("zero_seg_done_latency", 88'(done_cyc - t_start), 88'd1);
        check("zero_seg_no_write", 88'(wr_cnt), 88'd0);

        // Randomized runs under random backpressure
        for (int it = 0; it < 4; it++) begin
            int n, r;
            n = $urandom_range(1, 8);
            r = $urandom_range(1, 3);
            for (int s = 0; s < n; s++) begin
                int k;
                logic [7:0] op;
                k  = $urandom_range(0, 9);
                op = (k == 0) ? 8'd1 : (k == 1) ? 8'd255 : 8'd0;
                write_tab(s, instr(op, $urandom, 16'($urandom), $urandom), 1'b1);
            end
            resp_delay = $urandom_range(1, 30);
            fifo_rand = 1'b1;
            reset_run();
            predict_run(n, r);
            do_start(n, r);
            wait_done(1, 30000);
            fifo_rand = 1'b0;
            check("rand_write_count", 88'(wr_cnt), 88'(n * r));
        end

        // Reset while waiting on the second segment
        write_tab(0, instr(8'd0, $urandom, 16'($urandom), $urandom), 1'b1);
        write_tab(1, instr(8'd0, $urandom, 16'($urandom), $urandom), 1'b1);
        resp_delay = 0;
        resp_plan.push_back(5);
        resp_plan.push_back(0);
        reset_run();
        exp_wr.push_back(model_tab[0]);
        exp_wr.push_back(model_tab[1]);
        do_start(2, 1);
        wait_wr(2, 200);
        tick(10);
        check("pre_reset_seg_index", 88'(seg_index), 88'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_busy", 88'(busy), 88'd0);
        check("mid_reset_seg_index", 88'(seg_index), 88'd0);
        reset = 1'b0;
        tick(5);
        check("mid_reset_no_done", 88'(done_cnt), 88'd0);
        check("writes_all_seen", 88'(exp_wr.size()), 88'd0);
        check("dones_all_seen", 88'(exp_done.size()), 88'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
